// File: rtl/mem_arbiter.sv
// Shares one memory bus between the fetch (F) and data (M) ports of the core.
// Data has priority; fetch is forced through after STARVE_LIMIT data grants; stalled bus transfers time out.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_F,
  input  logic [31:0] pc_F,
  output logic [31:0] inst_F,
  output logic        inst_mem_ack_F,
  input  logic        dm_req_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic [3:0]  byte_en_M,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]        STARVE_ONE = SW'(1);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE   = TIMEOUT_W'(1);
  localparam logic                 TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic [3:0]           bus_be_q, bus_be_d;
  logic [31:0]          inst_q, inst_d;
  logic [31:0]          read_data_q, read_data_d;
  logic                 inst_ack_q, inst_ack_d;
  logic                 data_ack_q, data_ack_d;
  logic                 bus_err_q, bus_err_d;
  logic                 idle_s, grant_i_s, grant_d_s, timeout_s;

  // Grant decision and timeout detection.
  always_comb begin
    idle_s    = (state_q == IDLE);
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (idle_s && dm_req_M && !(if_req_F && (starve_cnt_q == STARVE_MAX))) begin
      grant_d_s = 1'b1;
    end else if (idle_s && if_req_F) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
    end
    timeout_s = TIMEOUT_EN && !idle_s && (wait_cnt_q == WAIT_LAST);
  end

  // Next-state for the FSM, bus fields and core-facing results.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    inst_d      = inst_q;
    read_data_d = read_data_q;
    inst_ack_d  = 1'b0;
    data_ack_d  = 1'b0;
    bus_err_d   = bus_err_q;
    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          state_d     = GNT_D;
          wait_cnt_d  = {TIMEOUT_W{1'b0}};
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_M;
          bus_addr_d  = alu_out_M;
          bus_wdata_d = write_data_M;
          bus_be_d    = mem_write_M ? byte_en_M : 4'hF;
        end else if (grant_i_s) begin
          state_d     = GNT_I;
          wait_cnt_d  = {TIMEOUT_W{1'b0}};
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = pc_F;
          bus_wdata_d = 32'h0;
          bus_be_d    = 4'hF;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        // An ack arriving on the timeout cycle still counts as a normal completion.
        if (bus_ack || timeout_s) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          bus_err_d = bus_ack ? bus_err_q : 1'b1;
          if (state_q == GNT_I) begin
            inst_ack_d = 1'b1;
            inst_d     = bus_ack ? bus_rdata : 32'h0;
          end else begin
            data_ack_d  = 1'b1;
            read_data_d = bus_ack ? bus_rdata : 32'h0;
          end
        end else if (wait_cnt_q != {TIMEOUT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Starvation counter: data grants while fetch waits.
  always_comb begin
    if (!if_req_F) begin
      starve_cnt_d = {SW{1'b0}};
    end else if (grant_i_s) begin
      starve_cnt_d = {SW{1'b0}};
    end else if (grant_d_s && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + STARVE_ONE;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= {SW{1'b0}};
      wait_cnt_q   <= {TIMEOUT_W{1'b0}};
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      bus_be_q     <= 4'h0;
      inst_q       <= 32'h0;
      read_data_q  <= 32'h0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      inst_q       <= inst_d;
      read_data_q  <= read_data_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign bus_be         = bus_be_q;
  assign inst_F         = inst_q;
  assign read_data_M    = read_data_q;
  assign inst_mem_ack_F = inst_ack_q;
  assign data_mem_ack_M = data_ack_q;
  assign bus_err        = bus_err_q;

endmodule
